// File: rtl/ndff_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with a valid/ready handshake on both sides,
// bubble collapse, synchronous flush and an incrementally maintained occupancy count.
module ndff_pipe #(
  parameter int              DW         = 1,
  parameter int              DEPTH      = 2,
  parameter logic [DW-1:0]   RST_VECTOR = {DW{1'b0}},
  parameter int              CW         = $clog2(DEPTH+1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          I_VALID,
  output logic          I_READY,
  input  logic [DW-1:0] I_DATA,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic [DW-1:0] O_DATA,
  output logic [CW-1:0] COUNT
);

  // Handshake: a transfer happens on a rising edge where VALID and READY are both 1.
  // I_READY may depend combinationally on O_READY and FLUSH; O_VALID/O_DATA come straight
  // from the last stage's registers and hold steady while stalled.

  logic [DEPTH-1:0] v;
  logic [DW-1:0]    d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] in_v;
  logic [DW-1:0]    in_d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // A stage advances unless it and every stage after it are full while O_READY is low;
  // this is the unrolled form of adv[i] = !v[i] | adv[i+1] with adv[DEPTH] = O_READY.
  always_comb begin : advance_chain
    logic tail_full;
    tail_full = 1'b1;
    adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      adv[i]    = ~tail_full | O_READY;
    end
  end

  always_comb begin
    in_v[0] = I_VALID;
    in_d[0] = I_DATA;
    for (int i = 1; i < DEPTH; i++) begin
      in_v[i] = v[i-1];
      in_d[i] = d[i-1];
    end
  end

  assign I_READY  = adv[0] & ~FLUSH;
  assign O_VALID  = v[DEPTH-1];
  assign O_DATA   = d[DEPTH-1];
  assign in_xfer  = I_VALID & I_READY;
  assign out_xfer = O_VALID & O_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v     <= '0;
      COUNT <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= RST_VECTOR;
    end else if (FLUSH) begin
      // Data registers keep their contents; only the valid bits are dropped.
      v     <= '0;
      COUNT <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= in_v[i];
          if (in_v[i]) d[i] <= in_d[i];
        end
      end
      case ({in_xfer, out_xfer})
        2'b10:   COUNT <= COUNT + CW'(1);
        2'b01:   COUNT <= COUNT - CW'(1);
        default: COUNT <= COUNT;
      endcase
    end
  end

`ifdef NCPU_ENABLE_ASSERT
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (I_VALID && $isunknown(I_DATA))
        $fatal(1, "ndff_pipe: I_VALID asserted with unknown I_DATA");
      if (COUNT != CW'($countones(v)))
        $fatal(1, "ndff_pipe: COUNT %0d differs from valid popcount %0d", COUNT, $countones(v));
    end
  end
`endif

endmodule
